// File: rtl/chunked_flag_comparator.sv
// Multi-cycle CMP unit: evaluates x - y CHUNK bits per cycle (LSB first) and
// registers full NZCV flags plus mode-selected gt/lt/eq for the CPSR writer.
module chunked_flag_comparator #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_unsigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             negative,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_flag_comparator: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // a producer holding valid keeps its payload stable until that edge.
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] x_sh, y_sh;
  logic             x_msb, y_msb;
  logic             mode_q;
  logic             carry_q;
  logic             zero_acc_q;
  logic [IDX_W-1:0] idx_q;

  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;
  logic             accept;
  logic             res_n, res_z, res_c, res_v;

  assign accept     = in_valid & in_ready;
  assign last_chunk = (idx_q == LAST_IDX);

  // Operands shift right as they are consumed, so the active chunk is always the low bits.
  assign chunk_sum = {1'b0, x_sh[CHUNK-1:0]} + {1'b0, ~y_sh[CHUNK-1:0]}
                   + (CHUNK+1)'(carry_q);

  assign res_n = chunk_sum[CHUNK-1];
  assign res_z = zero_acc_q & (chunk_sum[CHUNK-1:0] == '0);
  assign res_c = chunk_sum[CHUNK];
  assign res_v = (x_msb != y_msb) & (res_n != x_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (last_chunk) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sh       <= '0;
      y_sh       <= '0;
      x_msb      <= 1'b0;
      y_msb      <= 1'b0;
      mode_q     <= 1'b0;
      carry_q    <= 1'b0;
      zero_acc_q <= 1'b0;
      idx_q      <= '0;
      negative   <= 1'b0;
      zero       <= 1'b0;
      cout       <= 1'b0;
      overflow   <= 1'b0;
      gt         <= 1'b0;
      lt         <= 1'b0;
      eq         <= 1'b0;
    end else if (accept) begin
      x_sh       <= x;
      y_sh       <= y;
      x_msb      <= x[WIDTH-1];
      y_msb      <= y[WIDTH-1];
      mode_q     <= signed_unsigned;
      carry_q    <= 1'b1;
      zero_acc_q <= 1'b1;
      idx_q      <= '0;
    end else if (state == CALC) begin
      x_sh       <= x_sh >> CHUNK;
      y_sh       <= y_sh >> CHUNK;
      carry_q    <= res_c;
      zero_acc_q <= res_z;
      idx_q      <= idx_q + 1'b1;
      // Flags only update on the final chunk, so no partial result is ever visible.
      if (last_chunk) begin
        negative <= res_n;
        zero     <= res_z;
        cout     <= res_c;
        overflow <= res_v;
        eq       <= res_z;
        if (mode_q) begin
          lt <= res_n ^ res_v;
          gt <= ~(res_n ^ res_v) & ~res_z;
        end else begin
          lt <= ~res_c;
          gt <= res_c & ~res_z;
        end
      end
    end
  end

endmodule

// File: tb/tb_chunked_flag_comparator.sv
// Directed and swept checks of chunked_flag_comparator in three geometries
// (8/4, 8/8, 16/4) sharing clock, reset, operands and out_ready.
module tb_chunked_flag_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] x, y;
  logic        su;
  logic        out_ready;
  logic [2:0]  in_valid_v;
  wire  [2:0]  in_ready_v, out_valid_v;
  wire  [2:0]  neg_v, zero_v, cout_v, ovf_v, gt_v, lt_v, eq_v;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chunked_flag_comparator #(.WIDTH(8), .CHUNK(4)) u_dut_8x4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .x(x[7:0]), .y(y[7:0]), .signed_unsigned(su), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .negative(neg_v[0]), .zero(zero_v[0]), .cout(cout_v[0]),
    .overflow(ovf_v[0]), .gt(gt_v[0]), .lt(lt_v[0]), .eq(eq_v[0]));

  chunked_flag_comparator #(.WIDTH(8), .CHUNK(8)) u_dut_8x8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .x(x[7:0]), .y(y[7:0]), .signed_unsigned(su), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .negative(neg_v[1]), .zero(zero_v[1]), .cout(cout_v[1]),
    .overflow(ovf_v[1]), .gt(gt_v[1]), .lt(lt_v[1]), .eq(eq_v[1]));

  chunked_flag_comparator #(.WIDTH(16), .CHUNK(4)) u_dut_16x4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .x(x), .y(y), .signed_unsigned(su), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .negative(neg_v[2]), .zero(zero_v[2]), .cout(cout_v[2]),
    .overflow(ovf_v[2]), .gt(gt_v[2]), .lt(lt_v[2]), .eq(eq_v[2]));

  // Flag vector layout: {N, Z, C, V, gt, lt, eq}
  function automatic logic [6:0] flg(input int d);
    return {neg_v[d], zero_v[d], cout_v[d], ovf_v[d], gt_v[d], lt_v[d], eq_v[d]};
  endfunction

  // Reference built from integer arithmetic on the full operands.
  function automatic logic [6:0] ref_flags(input int w, input logic [15:0] xa,
                                           input logic [15:0] ya, input logic mode);
    int mask, xu, yu, xs, ys, diff, sdiff;
    logic n, z, c, v, g, l, e;
    mask  = (1 << w) - 1;
    xu    = int'(xa) & mask;
    yu    = int'(ya) & mask;
    diff  = (xu - yu) & mask;
    xs    = (xu >= (1 << (w - 1))) ? xu - (1 << w) : xu;
    ys    = (yu >= (1 << (w - 1))) ? yu - (1 << w) : yu;
    sdiff = xs - ys;
    n = ((diff >> (w - 1)) & 1) == 1;
    z = (diff == 0);
    c = (xu >= yu);
    v = (sdiff > (1 << (w - 1)) - 1) || (sdiff < -(1 << (w - 1)));
    e = (xu == yu);
    g = mode ? (xs > ys) : (xu > yu);
    l = mode ? (xs < ys) : (xu < yu);
    return {n, z, c, v, g, l, e};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with DUT d idle; returns once out_valid is seen.
  task automatic run_cmp(input int d, input logic [15:0] xa, input logic [15:0] ya,
                         input logic mode, input int exp_lat, output logic [6:0] got);
    int lat;
    check("in_ready_idle", in_ready_v[d], 1'b1);
    x = xa; y = ya; su = mode; in_valid_v[d] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    x = 16'($urandom); y = 16'($urandom); su = ~mode;
    check("in_ready_busy", in_ready_v[d], 1'b0);
    lat = 0;
    while (!out_valid_v[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", out_valid_v[d], 1'b1);
    check("latency", lat, exp_lat);
    got = flg(d);
  endtask

  task automatic ack(input int d);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ack_out_valid", out_valid_v[d], 1'b0);
    check("ack_in_ready", in_ready_v[d], 1'b1);
  endtask

  task automatic directed(input string tag, input logic [15:0] xa, input logic [15:0] ya,
                          input logic mode, input logic [6:0] exp);
    logic [6:0] got;
    run_cmp(0, xa, ya, mode, 2, got);
    check(tag, got, exp);
    ack(0);
  endtask

  initial begin
    logic [6:0]  got;
    logic [15:0] xa, ya;
    logic        mode;
    int          w, nc;

    rst_n = 1'b0; x = '0; y = '0; su = 1'b0; out_ready = 1'b0; in_valid_v = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_v, 3'b111);
    check("rst_out_valid", out_valid_v, 3'b000);
    check("rst_flags", flg(0), 7'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    directed("u_05_03",  16'h05, 16'h03, 1'b0, 7'b0010_100);
    directed("s_80_01",  16'h80, 16'h01, 1'b1, 7'b0011_010);
    directed("u_80_01",  16'h80, 16'h01, 1'b0, 7'b0011_100);
    directed("u_00_ff",  16'h00, 16'hFF, 1'b0, 7'b0000_010);
    directed("s_00_ff",  16'h00, 16'hFF, 1'b1, 7'b0000_100);
    directed("u_a5_a5",  16'hA5, 16'hA5, 1'b0, 7'b0110_001);
    directed("s_a5_a5",  16'hA5, 16'hA5, 1'b1, 7'b0110_001);
    directed("s_7f_80",  16'h7F, 16'h80, 1'b1, 7'b1001_100);

    // Backpressure: result must hold while new operands pulse in
    run_cmp(0, 16'h05, 16'h03, 1'b0, 2, got);
    check("bp_first", got, 7'b0010_100);
    for (int i = 0; i < 5; i++) begin
      x = 16'($urandom); y = 16'($urandom); su = ~su;
      in_valid_v[0] = (i % 2 == 0);
      @(posedge clk); #1;
      check("bp_out_valid", out_valid_v[0], 1'b1);
      check("bp_in_ready", in_ready_v[0], 1'b0);
      check("bp_flags", flg(0), 7'b0010_100);
    end
    in_valid_v[0] = 1'b0;
    ack(0);
    check("bp_flags_kept", flg(0), 7'b0010_100);

    // Reset one cycle into CALC, after a compare that left nonzero flags
    directed("pre_rst_a5", 16'hA5, 16'hA5, 1'b0, 7'b0110_001);
    x = 16'h37; y = 16'h12; su = 1'b0; in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid_v[0], 1'b0);
    check("mid_rst_in_ready", in_ready_v[0], 1'b1);
    check("mid_rst_flags", flg(0), 7'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_no_result", out_valid_v[0], 1'b0);
    directed("u_10_10", 16'h10, 16'h10, 1'b0, 7'b0110_001);

    // Swept operands on the 8/8 and 16/4 geometries
    for (int d = 1; d <= 2; d++) begin
      w  = (d == 1) ? 8 : 16;
      nc = (d == 1) ? 1 : 4;
      for (int i = 0; i < 24; i++) begin
        case (i)
          0: begin xa = 16'h0000; ya = 16'h0000; end
          1: begin xa = 16'hFFFF; ya = 16'h0001; end
          2: begin xa = 16'h8000; ya = 16'h7FFF; end
          3: begin xa = 16'h0080; ya = 16'h007F; end
          default: begin xa = 16'($urandom); ya = (i % 5 == 0) ? xa : 16'($urandom); end
        endcase
        mode = i[0];
        run_cmp(d, xa, ya, mode, nc, got);
        check((d == 1) ? "sweep_8x8" : "sweep_16x4", got, ref_flags(w, xa, ya, mode));
        ack(d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
